serial_parity_rx: RTL and testbench

Serial frame receiver and parity checker: the receive end of the team's XOR-based parity link. Deserialises a start/data/parity/stop frame arriving one bit per qualified clock, recomputes parity with an XOR accumulator and flags parity and framing errors. Sits between the serial line sampler and the parallel consumer logic.

---
 rtl/serial_parity_rx_pkg.sv | 17 +
 rtl/serial_parity_rx_par_acc.sv | 22 ++
 rtl/serial_parity_rx.sv | 127 ++++++++++++
 tb/tb_serial_parity_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_rx_pkg.sv
// Shared frame definitions for the XOR parity link.
// Used by both the receiver and the matching transmitter.
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } rx_state_e;

  localparam int DATA_W_DEF = 8;
  localparam bit PAR_EVEN   = 1'b0;
  localparam bit PAR_ODD    = 1'b1;

endpackage

// File: rtl/serial_parity_rx_par_acc.sv
// 1-bit XOR parity accumulator with clear and enable.
// Shared between the link transmitter and receiver.
module par_acc (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial start/data/parity/stop frame receiver.
// Deserialises LSB-first data and flags parity/framing errors.
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit ODD    = PAR_EVEN
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  rx_state_e         state_q;
  rx_state_e         state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic              perr_q;
  logic              perr_d;
  logic              acc_clr;
  logic              acc_en;
  logic              acc_q;
  logic              fire;

  par_acc u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .en      (acc_en),
    .d       (rx_bit),
    .q       (acc_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    perr_d  = perr_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_en && !rx_bit) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
      DATA: begin
        if (rx_en) begin
          sr_d   = {rx_bit, sr_q[DATA_W-1:1]};
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (rx_en) begin
          perr_d  = acc_q ^ rx_bit ^ ODD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (rx_en) begin
          fire    = 1'b1;
          state_d = rx_bit ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // a low stop bit never doubles as a new start bit
        if (rx_en && rx_bit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (fire) begin
        data <= sr_q;
      end
      data_valid <= fire;
      parity_err <= fire & perr_q;
      frame_err  <= fire & ~rx_bit;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx.
// Two instances share the line: even and odd parity sense.
module tb_serial_parity_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       rx_en;
  logic       rx_bit;
  logic [7:0] data0;
  logic       dv0;
  logic       pe0;
  logic       fe0;
  logic       busy0;
  logic [7:0] data1;
  logic       dv1;
  logic       pe1;
  logic       fe1;
  logic       busy1;

  int tests;
  int fails;
  exp_t q0[$];
  exp_t q1[$];

  serial_parity_rx #(.DATA_W(8), .ODD(1'b0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_en      (rx_en),
    .rx_bit     (rx_bit),
    .data       (data0),
    .data_valid (dv0),
    .parity_err (pe0),
    .frame_err  (fe0),
    .busy       (busy0)
  );

  serial_parity_rx #(.DATA_W(8), .ODD(1'b1)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_en      (rx_en),
    .rx_bit     (rx_bit),
    .data       (data1),
    .data_valid (dv1),
    .parity_err (pe1),
    .frame_err  (fe1),
    .busy       (busy1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (dv0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected valid", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("dut0 data", 32'(data0), 32'(e.d));
        chk("dut0 parity_err", 32'(pe0), 32'(e.pe));
        chk("dut0 frame_err", 32'(fe0), 32'(e.fe));
      end
    end else begin
      chk("dut0 errs idle", {30'd0, pe0, fe0}, 0);
    end
    if (dv1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected valid", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("dut1 data", 32'(data1), 32'(e.d));
        chk("dut1 parity_err", 32'(pe1), 32'(e.pe));
        chk("dut1 frame_err", 32'(fe1), 32'(e.fe));
      end
    end else begin
      chk("dut1 errs idle", {30'd0, pe1, fe1}, 0);
    end
  end

  // Drive at a negedge; return at the negedge after it was sampled.
  task automatic strobe(input logic b);
    rx_en  = 1'b1;
    rx_bit = b;
    @(negedge clock);
    rx_en  = 1'b0;
    rx_bit = 1'b1;
  endtask

  task automatic sbit(input logic b, input bit stall);
    if (stall) begin
      while ($urandom % 2 == 0) begin
        rx_en  = 1'b0;
        rx_bit = 1'($urandom);
        @(negedge clock);
      end
    end
    strobe(b);
  endtask

  task automatic frame(input logic [7:0] d,
                       input logic p,
                       input logic s,
                       input bit stall);
    sbit(1'b0, stall);
    chk("busy after start", 32'(busy0), 1);
    for (int i = 0; i < 8; i++) begin
      sbit(d[i], stall);
    end
    sbit(p, stall);
    sbit(s, stall);
  endtask

  task automatic expect2(input logic [7:0] d,
                         input logic pa, input logic pb,
                         input logic fe);
    q0.push_back('{d: d, pe: pa, fe: fe});
    q1.push_back('{d: d, pe: pb, fe: fe});
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    rx_en   = 1'b0;
    rx_bit  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_en  = 1'($urandom);
      rx_bit = 1'($urandom);
      @(negedge clock);
      chk("reset outs dut0",
          {21'd0, data0, dv0, pe0, fe0, busy0}, 0);
      chk("reset outs dut1",
          {21'd0, data1, dv1, pe1, fe1, busy1}, 0);
    end
    rx_en   = 1'b0;
    rx_bit  = 1'b1;
    reset_n = 1'b1;
    @(negedge clock);
    strobe(1'b1);
    chk("idle on high line", 32'(busy0), 0);

    // A5 good even-parity frame, back-to-back with a bad-parity copy
    expect2(8'hA5, 1'b0, 1'b1, 1'b0);
    frame(8'hA5, 1'b0, 1'b1, 0);
    chk("busy low after stop", 32'(busy0), 0);
    expect2(8'hA5, 1'b1, 1'b0, 1'b0);
    frame(8'hA5, 1'b1, 1'b1, 0);

    // 3C with a low stop bit, then a held-low break
    expect2(8'h3C, 1'b0, 1'b1, 1'b1);
    frame(8'h3C, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0);
      chk("busy in break", 32'(busy0), 1);
    end
    chk("data held in break", 32'(data0), 32'h3C);
    strobe(1'b1);
    chk("busy after break", 32'(busy0), 0);

    // A5 with random rx_en stalls
    expect2(8'hA5, 1'b0, 1'b1, 1'b0);
    frame(8'hA5, 1'b0, 1'b1, 1);
    strobe(1'b1);

    // reset after four data bits of a frame
    strobe(1'b0);
    for (int i = 0; i < 4; i++) begin
      strobe(1'($urandom));
    end
    reset_n = 1'b0;
    @(negedge clock);
    chk("busy in mid reset", 32'(busy0), 0);
    chk("data in mid reset", 32'(data0), 0);
    reset_n = 1'b1;
    strobe(1'b1);
    strobe(1'b1);
    expect2(8'h5A, 1'b0, 1'b1, 1'b0);
    frame(8'h5A, 1'b0, 1'b1, 0);
    strobe(1'b1);
    chk("data held after 5A", 32'(data0), 32'h5A);

    repeat (4) @(negedge clock);
    chk("dut0 frames left", q0.size(), 0);
    chk("dut1 frames left", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
